// File: rtl/wb_stage.sv
// Write-back stage: captures the instruction leaving MEM, waits for load data
// when needed, formats it and drives the register file write port for exactly
// one cycle per retiring instruction.
module wb_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic [2:0]  mem_funct3,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data,
  output logic        wb_stall,
  output logic        load_err,
  output logic [1:0]  dbg_state_o
);

  // Handshake with MEM: an instruction is taken on a rising edge when
  // mem_valid=1 and wb_stall=0. While wb_stall=1 the MEM stage must hold its
  // outputs stable; mem_valid is not looked at during that time.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '1 : CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [4:0]    wr_rd_q, wr_rd_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          we_q, we_d;
  logic [4:0]    ld_rd_q, ld_rd_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic [1:0]    ld_off_q, ld_off_d;
  logic          ld_we_q, ld_we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_err_q, load_err_d;

  // Select and extend the loaded lane; the half lane ignores offset[0].
  function automatic logic [31:0] extract(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // State and datapath registers; reset discards any outstanding load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_rd_q    <= '0;
      wr_data_q  <= '0;
      we_q       <= 1'b0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      ld_we_q    <= 1'b0;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_rd_q    <= wr_rd_d;
      wr_data_q  <= wr_data_d;
      we_q       <= we_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      ld_we_q    <= ld_we_d;
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end

  // Next-state: accept from MEM in IDLE/WRITE, resolve load or timeout in WAIT.
  always_comb begin
    state_d    = state_q;
    wr_rd_d    = wr_rd_q;
    wr_data_d  = wr_data_q;
    we_d       = we_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    ld_we_d    = ld_we_q;
    cnt_d      = cnt_q;
    load_err_d = 1'b0;
    case (state_q)
      S_IDLE, S_WRITE: begin
        if (!mem_valid) begin
          state_d = S_IDLE;
        end else if (!mem_MemtoReg) begin
          state_d   = S_WRITE;
          wr_rd_d   = mem_rd;
          wr_data_d = mem_alu_result;
          we_d      = mem_RegWrite && (mem_rd != 5'd0);
        end else begin
          state_d  = S_WAIT;
          ld_rd_d  = mem_rd;
          ld_f3_d  = mem_funct3;
          ld_off_d = mem_alu_result[1:0];
          ld_we_d  = mem_RegWrite;
          cnt_d    = '0;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          // Data beats the timeout when both land on the same edge.
          state_d   = S_WRITE;
          wr_rd_d   = ld_rd_q;
          wr_data_d = extract(ld_f3_q, ld_off_q, dmem_rdata);
          we_d      = ld_we_q && (ld_rd_q != 5'd0);
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            state_d    = S_IDLE;
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs; the write port only fires in WRITE.
  always_comb begin
    RegWrite       = (state_q == S_WRITE) && we_q;
    Write_register = wr_rd_q;
    Write_data     = wr_data_q;
    wb_stall       = (state_q == S_WAIT);
    load_err       = load_err_q;
    dbg_state_o    = state_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage built with a short load timeout.
module tb_wb_stage;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [31:0] RDATA   = 32'h80FF_7F01;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_RegWrite, mem_MemtoReg;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic [2:0]  mem_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        wb_stall, load_err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  wb_stage #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_RegWrite   (mem_RegWrite),
    .mem_MemtoReg   (mem_MemtoReg),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .mem_funct3     (mem_funct3),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data),
    .wb_stall       (wb_stall),
    .load_err       (load_err),
    .dbg_state_o    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic we, input logic [31:0] alu);
    mem_valid      = 1'b1;
    mem_MemtoReg   = 1'b0;
    mem_RegWrite   = we;
    mem_rd         = rd;
    mem_alu_result = alu;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    mem_valid      = 1'b1;
    mem_MemtoReg   = 1'b1;
    mem_RegWrite   = 1'b1;
    mem_rd         = rd;
    mem_funct3     = f3;
    mem_alu_result = {30'h0400_0000, off};
  endtask

  task automatic idle_in();
    mem_valid    = 1'b0;
    mem_MemtoReg = 1'b0;
    mem_RegWrite = 1'b0;
  endtask

  // Load with data returned on the third edge after accept.
  task automatic run_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] exp, input logic exp_we);
    int n;
    set_load(rd, f3, off);
    dmem_rdata = RDATA;
    tick();
    idle_in();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (wb_stall) n++;
      if (i == 2) dmem_rvalid = 1'b1;
      tick();
    end
    dmem_rvalid = 1'b0;
    check({tag, "_stall_cycles"}, n, 3);
    check({tag, "_stall_off"}, {31'd0, wb_stall}, 0);
    check({tag, "_we"}, {31'd0, RegWrite}, {31'd0, exp_we});
    if (exp_we) begin
      check({tag, "_wreg"}, {27'd0, Write_register}, {27'd0, rd});
      check({tag, "_wdata"}, Write_data, exp);
    end
    tick();
    check({tag, "_we_after"}, {31'd0, RegWrite}, 0);
  endtask

  initial begin
    int n;
    int seen_we;
    rst = 1'b1;
    idle_in();
    mem_rd = '0; mem_alu_result = '0; mem_funct3 = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_we", {31'd0, RegWrite}, 0);
    check("rst_wreg", {27'd0, Write_register}, 0);
    check("rst_wdata", Write_data, 0);
    check("rst_stall", {31'd0, wb_stall}, 0);
    check("rst_err", {31'd0, load_err}, 0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    tick();

    // Single non-load
    set_alu(5'd5, 1'b1, 32'h1234_5678);
    tick();
    idle_in();
    check("alu_we", {31'd0, RegWrite}, 1);
    check("alu_wreg", {27'd0, Write_register}, 5);
    check("alu_wdata", Write_data, 32'h1234_5678);
    tick();
    check("alu_we_after", {31'd0, RegWrite}, 0);
    check("alu_wreg_hold", {27'd0, Write_register}, 5);
    check("alu_wdata_hold", Write_data, 32'h1234_5678);

    // Back-to-back non-loads to x1, x2, x0
    set_alu(5'd1, 1'b1, 32'hAAAA_0001);
    tick();
    check("b2b1_we", {31'd0, RegWrite}, 1);
    check("b2b1_wreg", {27'd0, Write_register}, 1);
    check("b2b1_wdata", Write_data, 32'hAAAA_0001);
    check("b2b1_stall", {31'd0, wb_stall}, 0);
    set_alu(5'd2, 1'b1, 32'hBBBB_0002);
    tick();
    check("b2b2_we", {31'd0, RegWrite}, 1);
    check("b2b2_wreg", {27'd0, Write_register}, 2);
    check("b2b2_wdata", Write_data, 32'hBBBB_0002);
    check("b2b2_stall", {31'd0, wb_stall}, 0);
    set_alu(5'd0, 1'b1, 32'hCCCC_0003);
    tick();
    idle_in();
    check("b2b3_we_x0", {31'd0, RegWrite}, 0);
    check("b2b3_state", {30'd0, dbg_state}, {30'd0, ST_WRITE});
    check("b2b3_stall", {31'd0, wb_stall}, 0);
    tick();
    check("b2b_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // Load sweep on 0x80FF7F01
    run_load("lb3",  5'd10, 3'b000, 2'd3, 32'hFFFF_FF80, 1'b1);
    run_load("lbu1", 5'd11, 3'b100, 2'd1, 32'h0000_007F, 1'b1);
    run_load("lh2",  5'd12, 3'b001, 2'd2, 32'hFFFF_80FF, 1'b1);
    run_load("lhu0", 5'd13, 3'b101, 2'd0, 32'h0000_7F01, 1'b1);
    run_load("lw",   5'd14, 3'b010, 2'd2, 32'h80FF_7F01, 1'b1);
    run_load("lb2",  5'd15, 3'b000, 2'd2, 32'hFFFF_FFFF, 1'b1);
    run_load("lbu0", 5'd16, 3'b100, 2'd0, 32'h0000_0001, 1'b1);
    run_load("lh3",  5'd17, 3'b001, 2'd3, 32'hFFFF_80FF, 1'b1);
    run_load("f3_011", 5'd18, 3'b011, 2'd1, 32'h80FF_7F01, 1'b1);
    run_load("ld_x0", 5'd0, 3'b010, 2'd0, 32'h0, 1'b0);

    // Timeout: rvalid never comes
    set_load(5'd7, 3'b010, 2'd0);
    tick();
    idle_in();
    n = 0;
    seen_we = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_stall) n++;
      if (RegWrite) seen_we++;
      tick();
    end
    check("to_stall_cycles", n, 4);
    check("to_no_write", seen_we, 0);
    check("to_err_pulse", {31'd0, load_err}, 1);
    check("to_we", {31'd0, RegWrite}, 0);
    check("to_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("to_stall_off", {31'd0, wb_stall}, 0);
    tick();
    check("to_err_clear", {31'd0, load_err}, 0);
    check("to_we_later", {31'd0, RegWrite}, 0);

    // rvalid on the timeout edge wins
    set_load(5'd8, 3'b010, 2'd0);
    dmem_rdata = 32'h0BAD_F00D;
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_rvalid = 1'b1;
      tick();
    end
    dmem_rvalid = 1'b0;
    check("race_we", {31'd0, RegWrite}, 1);
    check("race_err", {31'd0, load_err}, 0);
    check("race_wreg", {27'd0, Write_register}, 8);
    check("race_wdata", Write_data, 32'h0BAD_F00D);
    tick();
    check("race_err_after", {31'd0, load_err}, 0);

    // Reset mid-WAIT, late rvalid ignored
    set_load(5'd9, 3'b010, 2'd0);
    tick();
    idle_in();
    tick();
    check("rw_pre_stall", {31'd0, wb_stall}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_async_stall", {31'd0, wb_stall}, 0);
    check("rw_async_we", {31'd0, RegWrite}, 0);
    check("rw_async_wreg", {27'd0, Write_register}, 0);
    check("rw_async_wdata", Write_data, 0);
    check("rw_async_err", {31'd0, load_err}, 0);
    check("rw_async_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    seen_we = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) dmem_rvalid = 1'b0;
      if (RegWrite) seen_we++;
    end
    check("rw_no_write", seen_we, 0);
    check("rw_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage pipeline. It is the writer end of the ID-stage register file write port.
- Captures the instruction leaving MEM and waits for load data from data memory when needed. It then formats the result (byte/half/word, signed/unsigned) and drives RegWrite/Write_register/Write_data for exactly one cycle per retiring instruction.
- Stalls upstream while a load response is outstanding and flags load timeouts.

Parameters:
- TIMEOUT, 255: number of consecutive WAIT cycles without dmem_rvalid before the load is abandoned; 0 disables the timeout.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_valid  input  1  MEM stage presents an instruction this cycle
- mem_RegWrite  input  1  instruction writes rd
- mem_MemtoReg  input  1  instruction is a load (result comes from dmem)
- mem_rd  input  5  destination register
- mem_alu_result  input  32  ALU result; bits [1:0] are the load byte offset for loads
- mem_funct3  input  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- dmem_rvalid  input  1  load data valid; sampled only in WAIT
- dmem_rdata  input  32  load data word, little-endian
- RegWrite  output  1  register file write enable
- Write_register  output  5  register file write address
- Write_data  output  32  register file write data
- wb_stall  output  1  high while in WAIT; upstream must hold MEM contents
- load_err  output  1  one-cycle pulse on load timeout

Behaviour:
- States: IDLE (nothing to write), WRITE (write port active this cycle), WAIT (load outstanding). Reset state is IDLE.
- Reset values: RegWrite=0, Write_register=0, Write_data=0, wb_stall=0, load_err=0, timeout counter=0.
- Asynchronous rst from any state returns to IDLE immediately and discards any pending load. A dmem_rvalid arriving after reset is ignored.
- Accept rule: in IDLE or WRITE, wb_stall=0. On the rising edge:
  - mem_valid=0 -> IDLE.
  - mem_valid=1 and mem_MemtoReg=0 -> WRITE. Latch rd, Write_data=mem_alu_result, we_q = mem_RegWrite && (mem_rd != 0).
  - mem_valid=1 and mem_MemtoReg=1 -> WAIT. Latch rd, funct3, offset=mem_alu_result[1:0] and mem_RegWrite; clear the counter.
- Back-to-back instructions are accepted every cycle, so WRITE can be followed directly by WRITE.
- WAIT behaviour:
  - wb_stall=1 combinationally from state; mem_valid is ignored.
  - dmem_rvalid=1 at an edge -> WRITE, with Write_data = extract(dmem_rdata) and we_q = latched RegWrite && rd != 0.
  - Otherwise the counter increments. If TIMEOUT != 0 and this is the TIMEOUT-th consecutive cycle without rvalid -> IDLE, load_err=1 for one cycle, no register write.
  - rvalid on the same edge as the timeout wins: data is written and load_err stays 0.
- Outputs are registered. RegWrite = (state==WRITE) && we_q. Write_register/Write_data hold their last values when RegWrite=0.
- Latency:
  - Non-load: the write cycle is the cycle after the accept edge.
  - Load: the write cycle is the cycle after the edge on which rvalid is sampled, so the minimum is 2 cycles after accept.
- extract:
  - LB: byte at offset, sign-extended; LBU: zero-extended.
  - LH: half selected by offset[1], sign-extended; LHU: zero-extended. offset[0] is ignored (misaligned halves are not trapped here).
  - LW and any other funct3: full word; offset is ignored.
- x0 protection: rd=0 never produces RegWrite=1.
- Counter width: $clog2(TIMEOUT+1), minimum 1. It saturates rather than wraps when TIMEOUT=0.

Test Plan:
- Reset, then a non-load: mem_valid=1, RegWrite=1, rd=5, alu=0x1234_5678 -> next cycle RegWrite=1, Write_register=5, Write_data=0x12345678; following cycle RegWrite=0 if no new input.
- Back-to-back non-loads to rd=1, rd=2, rd=0 on consecutive cycles -> three consecutive write cycles with RegWrite=1,1,0, and wb_stall stays 0 throughout.
- Load sweep with dmem_rdata=0x80FF_7F01, rvalid 3 cycles after accept:
  - LB offset 3 -> 0xFFFFFF80.
  - LBU offset 1 -> 0x0000007F.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - wb_stall=1 for exactly 3 cycles for each load.
- Timeout with TIMEOUT=4 and rvalid never asserted -> wb_stall high for 4 cycles, then load_err pulses once, RegWrite never 1, and state returns to IDLE. A repeat run with rvalid on the 4th cycle -> write occurs and load_err=0.
- rst asserted mid-WAIT, then rvalid pulses after reset deasserts -> all outputs 0 asynchronously and no write is ever produced.
